// File: rtl/uart_tx_unit_pkg.sv
// Shared UART definitions: FSM states, baud/parity codes and the baud divisor
// function used by both the transmitter and the RxUnit receiver.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

   typedef enum logic [1:0] {
      BAUD_2400  = 2'b00,
      BAUD_4800  = 2'b01,
      BAUD_9600  = 2'b10,
      BAUD_19200 = 2'b11
   } baud_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   localparam int DIV_W = 15;

   // Clocks per bit, truncated toward zero.
   function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_freq,
                                                 input logic [1:0] code);
      int unsigned rate;
      case (code)
         BAUD_2400: rate = 2400;
         BAUD_4800: rate = 4800;
         BAUD_9600: rate = 9600;
         default:   rate = 19200;
      endcase
      return DIV_W'(clk_freq / rate);
   endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// Request/line bundle between a word producer and the UART transmitter.
interface uart_tx_unit_if #(parameter int DATA_BITS = 8);
   logic                 send;
   logic [DATA_BITS-1:0] data_in;
   logic [1:0]           parity_type;
   logic [1:0]           baud_rate;
   logic                 data_tx;
   logic                 active_flag;
   logic                 done_flag;

   modport master (output send, data_in, parity_type, baud_rate,
                   input  data_tx, active_flag, done_flag);
   modport slave  (input  send, data_in, parity_type, baud_rate,
                   output data_tx, active_flag, done_flag);
endinterface

// File: rtl/uart_tx_unit_baud_tick.sv
// Bit-period timer: reloadable down-counter, bit_tick marks the last clock of a bit.
module uart_baud_tick
   import uart_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) begin
         div_q <= '0;
         cnt   <= '0;
      end else if (load) begin
         div_q <= div;
         cnt   <= div - DIV_W'(1);
      end else if (cnt == '0) begin
         cnt   <= div_q - DIV_W'(1);
      end else begin
         cnt   <= cnt - DIV_W'(1);
      end
   end

   assign bit_tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: one start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits. Request fields are frozen at accept.
module uart_tx_unit
   import uart_pkg::*;
#(
   parameter int          DATA_BITS = 8,
   parameter bit          PARITY_EN = 1'b1,
   parameter int          STOP_BITS = 1,
   parameter int unsigned CLK_FREQ  = 50000000
) (
   input logic           clock,
   input logic           reset_n,
   uart_tx_unit_if.slave tx
);

   localparam int IW = $clog2(DATA_BITS) + 1;
   localparam logic [DIV_W-1:0] DIV_TAB [4] = '{
      baud_div(CLK_FREQ, BAUD_2400), baud_div(CLK_FREQ, BAUD_4800),
      baud_div(CLK_FREQ, BAUD_9600), baud_div(CLK_FREQ, BAUD_19200)};

   tx_state_e            state, state_nxt;
   logic [DATA_BITS-1:0] shreg;
   logic [IW-1:0]        idx;
   logic                 par_bit, has_par, done_q;
   logic                 bit_tick, accept, last_data, last_stop;

   assign accept    = (state == IDLE) && tx.send;
   assign last_data = (idx == IW'(DATA_BITS - 1));
   assign last_stop = (idx == IW'(STOP_BITS - 1));

   uart_baud_tick u_tick (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (accept),
      .div      (DIV_TAB[tx.baud_rate]),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tx.send) state_nxt = START;
         START:   if (bit_tick) state_nxt = DATA;
         DATA:    if (bit_tick && last_data) state_nxt = has_par ? PARITY : STOP;
         PARITY:  if (bit_tick) state_nxt = STOP;
         STOP:    if (bit_tick && last_stop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // idx counts data bits in DATA, then is reused to count stop bits.
   always_ff @(posedge clock or posedge reset_n) begin
      if (reset_n) begin
         shreg   <= '0;
         idx     <= '0;
         par_bit <= 1'b0;
         has_par <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= (state == STOP) && bit_tick && last_stop;
         if (accept) begin
            shreg   <= tx.data_in;
            idx     <= '0;
            has_par <= PARITY_EN && (tx.parity_type == PAR_ODD || tx.parity_type == PAR_EVEN);
            par_bit <= (tx.parity_type == PAR_ODD) ? ~^tx.data_in : ^tx.data_in;
         end else if (bit_tick) begin
            if (state == DATA) begin
               shreg <= shreg >> 1;
               idx   <= last_data ? '0 : idx + IW'(1);
            end else if (state == STOP) begin
               idx   <= idx + IW'(1);
            end
         end
      end
   end

   always_comb begin
      tx.data_tx = 1'b1;
      case (state)
         START:   tx.data_tx = 1'b0;
         DATA:    tx.data_tx = shreg[0];
         PARITY:  tx.data_tx = par_bit;
         default: tx.data_tx = 1'b1;
      endcase
   end

   assign tx.active_flag = (state != IDLE);
   assign tx.done_flag   = done_q;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed + random frames checked cycle-by-cycle against a bit-list model of
// the frame, plus a mid-bit line decoder acting as the receiving end.
module tb_uart_tx_unit;

   localparam int unsigned CLK_HZ = 240000;  // divisors 100/50/25/12

   logic clock = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   uart_tx_unit_if #(.DATA_BITS(8)) tx ();

   uart_tx_unit #(.DATA_BITS(8), .PARITY_EN(1'b1), .STOP_BITS(1), .CLK_FREQ(CLK_HZ)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .tx      (tx)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int bit_clocks(input logic [1:0] br);
      int unsigned rate;
      case (br)
         2'd0:    rate = 2400;
         2'd1:    rate = 4800;
         2'd2:    rate = 9600;
         default: rate = 19200;
      endcase
      return int'(CLK_HZ / rate);
   endfunction

   task automatic idle_chk();
      @(negedge clock);
      chk("idle_done", tx.done_flag, 0);
      chk("idle_active", tx.active_flag, 0);
      chk("idle_line", tx.data_tx, 1);
   endtask

   // Entered and left at a negedge. hold keeps send high for chaining;
   // poke_at pulses send with 8'hFF mid-frame; rst_at resets mid-frame.
   task automatic do_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] br,
                           input bit hold, input int poke_at, input int rst_at);
      int  div, bad, ones;
      bit  q[$];
      bit  smp[$];
      logic [7:0] rx;
      bit  use_par, start_err, par_err, stop_err;
      div  = bit_clocks(br);
      ones = $countones(d);
      use_par = (pt == 2'b01) || (pt == 2'b10);
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
      if (use_par) q.push_back((pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1));
      q.push_back(1'b1);

      tx.send = 1'b1; tx.data_in = d; tx.parity_type = pt; tx.baud_rate = br;
      @(posedge clock);
      bad = 0;
      for (int c = 0; c < q.size() * div; c++) begin
         @(negedge clock);
         if (tx.data_tx !== q[c / div] || tx.active_flag !== 1'b1 || tx.done_flag !== 1'b0) bad++;
         if (c % div == div / 2) smp.push_back(tx.data_tx);
         if (c == 0) begin
            if (!hold) tx.send = 1'b0;
            tx.data_in = 8'($urandom); tx.parity_type = 2'($urandom); tx.baud_rate = 2'($urandom);
         end
         if (poke_at >= 0 && c == poke_at) begin tx.send = 1'b1; tx.data_in = 8'hFF; end
         if (poke_at >= 0 && c == poke_at + 1) tx.send = 1'b0;
         if (c == rst_at) begin
            reset_n = 1'b1;
            #1;
            chk("rst_async_line", tx.data_tx, 1);
            chk("rst_async_active", tx.active_flag, 0);
            tx.send = 1'b0;
            repeat (3) begin
               @(negedge clock);
               chk("rst_no_done", tx.done_flag, 0);
            end
            reset_n = 1'b0;
            return;
         end
      end
      chk("frame_bad_cycles", bad, 0);

      // Receiver view: sample each bit at its middle.
      rx = '0;
      for (int i = 0; i < 8; i++) rx[i] = smp[1 + i];
      start_err = smp[0] != 1'b0;
      par_err   = use_par && ((($countones(rx) + int'(smp[9])) % 2 == 1) != (pt == 2'b01));
      stop_err  = smp[smp.size() - 1] != 1'b1;
      chk("rx_data", rx, d);
      chk("rx_err", {start_err, par_err, stop_err}, 0);

      @(negedge clock);
      chk("done_pulse", tx.done_flag, 1);
      chk("done_active", tx.active_flag, 0);
      chk("done_line", tx.data_tx, 1);
   endtask

   initial begin
      reset_n = 1'b1;
      tx.send = 1'b0; tx.data_in = '0; tx.parity_type = '0; tx.baud_rate = '0;
      repeat (3) @(negedge clock);
      chk("reset_line", tx.data_tx, 1);
      chk("reset_active", tx.active_flag, 0);
      chk("reset_done", tx.done_flag, 0);
      reset_n = 1'b0;
      idle_chk();

      do_frame(8'hA5, 2'b01, 2'b10, 0, -1, -1); idle_chk();
      do_frame(8'h3C, 2'b10, 2'b10, 0, -1, -1); idle_chk();
      do_frame(8'hF0, 2'b01, 2'b11, 0, -1, -1); idle_chk();
      do_frame(8'h55, 2'b00, 2'b10, 0, -1, -1); idle_chk();
      do_frame(8'h5A, 2'b11, 2'b00, 0, -1, -1); idle_chk();

      // Mid-frame send is dropped: one done, then quiet.
      do_frame(8'hA5, 2'b01, 2'b01, 0, 137, -1);
      idle_chk(); idle_chk();

      // Reset during data bit 3 at 9600 (25 clocks/bit), then recover.
      do_frame(8'hC3, 2'b10, 2'b10, 0, -1, 4 * 25 + 12);
      idle_chk();
      do_frame(8'h81, 2'b01, 2'b10, 0, -1, -1); idle_chk();

      // Back-to-back with send held high between frames.
      do_frame(8'hA5, 2'b01, 2'b10, 1, -1, -1);
      do_frame(8'h3C, 2'b10, 2'b10, 1, -1, -1);
      do_frame(8'hF0, 2'b01, 2'b11, 0, -1, -1);
      idle_chk();

      for (int k = 0; k < 8; k++) begin
         bit b2b;
         b2b = (k != 7) && ($urandom_range(0, 1) == 1);
         do_frame(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), b2b, -1, -1);
         if (!b2b) idle_chk();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_unit.md
Name: uart_tx_unit

Overview:
UART transmitter, counterpart of the RxUnit receiver: serialises one parallel word per request into a start/data/parity/stop frame on data_tx.
Uses the same parity_type and baud_rate encodings and the same 50 MHz system clock as the receiver, so it drives RxUnit's data_tx input directly in loopback.
Signals frame progress with active_flag and frame completion with done_flag.

Parameters:
DATA_BITS, 8, payload width; sent LSB first.
PARITY_EN, 1, 1 = parity bit inserted when parity_type selects odd or even; 0 = never inserted.
STOP_BITS, 1, number of stop bits (1 or 2).
CLK_FREQ, 50000000, system clock frequency in Hz; used to derive bit divisors.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  reset, asynchronous, active-high.
send  input  1  request; sampled only in IDLE.
data_in  input  DATA_BITS  word to transmit; captured when send is accepted.
parity_type  input  2  00 none, 01 odd, 10 even, 11 none; captured on accept.
baud_rate  input  2  00 2400, 01 4800, 10 9600, 11 19200; captured on accept.
data_tx  output  1  serial line; idles high.
active_flag  output  1  high from the start bit through the last stop bit.
done_flag  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (async, reset_n=1): data_tx=1, active_flag=0, done_flag=0; FSM=IDLE; all counters and shadow registers cleared.
- Divisor DIV = floor(CLK_FREQ/baud), computed at elaboration: 2400→20833, 4800→10416, 9600→5208, 19200→2604. Counter is 15 bits.
- Every bit, including each stop bit, holds for exactly DIV clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - send=1 at a posedge → latch data_in, parity_type and baud_rate.
  - Next cycle: state=START, data_tx=0, active_flag=1.
- START (DIV cycles) → DATA.
- DATA: data_tx=shreg[0]; after each DIV cycles, shift and increment the bit index. After DATA_BITS bits → PARITY if PARITY_EN=1 and latched parity_type ∈ {01,10}; else → STOP.
- PARITY: odd → ~^data; even → ^data; held DIV cycles → STOP.
- STOP: data_tx=1 for STOP_BITS×DIV cycles → IDLE. In that first IDLE cycle: done_flag=1 for exactly one cycle, active_flag=0.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)×DIV cycles, P ∈ {0,1}. Latency from send accepted to the start-bit edge: 1 cycle.
- send while active_flag=1 is ignored; it is not queued.
- send high in the done_flag cycle is accepted, so back-to-back frames have a 1-cycle idle gap.
- Changes to data_in, parity_type or baud_rate mid-frame have no effect on the frame in flight.
- Reset mid-frame: data_tx returns to 1 immediately; no done_flag pulse.
- send held high continuously: a new frame starts each time IDLE is reached.

Decomposition:
- Package uart_pkg:
  - state enum;
  - baud codes BAUD_2400..BAUD_19200;
  - parity codes PAR_NONE=00, PAR_ODD=01, PAR_EVEN=10;
  - constant function for the divisor from CLK_FREQ and baud code.
- The package is shared with RxUnit.
- Sub-module uart_baud_tick: loadable down-counter. Given a latched divisor it emits bit_tick on the last cycle of each bit, and restarts on FSM load.

Test Plan:
- 8'hA5, 9600, odd → line 0,1,0,1,0,0,1,0,1,1(parity),1(stop). Each bit 5208 cycles, 57288 cycles total; done_flag pulses once.
- 8'h3C, 9600, even → parity bit 0; 8'hF0, 19200, odd → parity bit 1, bit time 2604 cycles.
- parity_type=00 with 8'h55 → 10-bit frame, no parity slot, 52080 cycles at 9600.
- send pulsed mid-frame with data_in=8'hFF → ignored; the frame in flight is unchanged and exactly one done_flag occurs.
- reset_n asserted during the DATA bit 3 → data_tx=1 and active_flag=0 asynchronously. After release, a new 8'h81 frame is sent correctly.
- Loopback into RxUnit: 8'hA5/odd/9600, 8'h3C/even/9600, 8'hF0/odd/19200, back-to-back → data_out matches each word and error_flag=000.
